// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache set controller: widths and the FSM state encoding.
package includes;

   localparam int LINE_WORDS = 4;
   localparam int W_DATA     = 32 * LINE_WORDS;
   localparam int W_CTAG     = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      WB,
      REFILL
   } cache_ctrl_state_t;

endpackage

// File: rtl/cache_ctrl_line_merge.sv
// Replaces one 32-bit word of a cache line; everything else passes through untouched.
module line_merge #(
   parameter  int LINE_WORDS = 4,
   localparam int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic [LINE_WORDS*32-1:0] line_in,
   input  logic [OFF_W-1:0]         off,
   input  logic [31:0]              word,
   output logic [LINE_WORDS*32-1:0] line_out
);

   always_comb begin
      line_out                     = line_in;
      line_out[{off, 5'b0} +: 32] = word;
   end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for one 4-way set: lookup, hit service, dirty write-back,
// refill and replay of the original access.
module cache_ctrl
   import includes::*;
#(
   parameter  int LINE_WORDS = 4,
   localparam int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cpu_req,
   output logic              cpu_ready,
   input  logic              cpu_we,
   input  logic [W_CTAG-1:0] cpu_tag,
   input  logic [OFF_W-1:0]  cpu_off,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ack,
   output logic [31:0]       cpu_rdata,

   output logic              set_rd,
   output logic              set_we,
   output logic              set_wp,
   output logic              set_wd,
   output logic [W_CTAG-1:0] set_ctag,
   output logic [W_CTAG-1:0] set_ctag_w,
   output logic [W_DATA-1:0] set_data_w,
   input  logic              set_hit,
   input  logic [W_DATA-1:0] set_h_data,
   input  logic              set_r_dirty,
   input  logic [W_CTAG-1:0] set_r_ctag,
   input  logic [W_DATA-1:0] set_r_data,

   output logic              mem_req,
   output logic              mem_we,
   output logic [W_CTAG-1:0] mem_tag,
   output logic [W_DATA-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [W_DATA-1:0] mem_rdata
);

   cache_ctrl_state_t state, state_nx;

   logic              req_we;
   logic [W_CTAG-1:0] req_tag;
   logic [OFF_W-1:0]  req_off;
   logic [31:0]       req_wdata;
   logic [W_DATA-1:0] merged_line;
   logic              accept;

   assign accept = cpu_req & cpu_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_we    <= 1'b0;
         req_tag   <= '0;
         req_off   <= '0;
         req_wdata <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_tag;
            req_off   <= cpu_off;
            req_wdata <= cpu_wdata;
         end
      end
   end

   line_merge #(.LINE_WORDS(LINE_WORDS)) u_line_merge (
      .line_in  (set_h_data),
      .off      (req_off),
      .word     (req_wdata),
      .line_out (merged_line)
   );

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_nx   = state;
      cpu_ready  = 1'b0;
      cpu_ack    = 1'b0;
      cpu_rdata  = '0;
      set_rd     = 1'b0;
      set_we     = 1'b0;
      set_wp     = 1'b0;
      set_wd     = 1'b0;
      set_ctag   = '0;
      set_ctag_w = '0;
      set_data_w = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_tag    = '0;
      mem_wdata  = '0;

      unique case (state)
         IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) state_nx = LOOKUP;
         end

         LOOKUP: begin
            set_ctag = req_tag;
            if (set_hit) begin
               set_rd   = 1'b1;
               cpu_ack  = 1'b1;
               state_nx = IDLE;
               if (req_we) begin
                  set_we     = 1'b1;
                  set_wd     = 1'b1;
                  set_ctag_w = req_tag;
                  set_data_w = merged_line;
                  cpu_rdata  = req_wdata;
               end else begin
                  cpu_rdata = set_h_data[{req_off, 5'b0} +: 32];
               end
            end else begin
               state_nx = set_r_dirty ? WB : REFILL;
            end
         end

         // Victim outputs hold still here: replacement state moves only on rd & hit.
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_tag   = set_r_ctag;
            mem_wdata = set_r_data;
            if (mem_ack) state_nx = REFILL;
         end

         REFILL: begin
            mem_req = 1'b1;
            mem_tag = req_tag;
            if (mem_ack) begin
               set_we     = 1'b1;
               set_wp     = 1'b1;
               set_ctag_w = req_tag;
               set_data_w = mem_rdata;
               state_nx   = LOOKUP;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural 4-way PLRU set, latency-programmable
// memory, and a reference memory image feeding a scoreboard of expected CPU read data.
`timescale 1ns/1ps
module tb_cache_ctrl;
   import includes::*;

   localparam int LW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_ready, cpu_we, cpu_ack;
   logic [W_CTAG-1:0] cpu_tag;
   logic [1:0]        cpu_off;
   logic [31:0]       cpu_wdata, cpu_rdata;
   logic              set_rd, set_we, set_wp, set_wd, set_hit, set_r_dirty;
   logic [W_CTAG-1:0] set_ctag, set_ctag_w, set_r_ctag;
   logic [W_DATA-1:0] set_data_w, set_h_data, set_r_data;
   logic              mem_req, mem_we, mem_ack;
   logic [W_CTAG-1:0] mem_tag;
   logic [W_DATA-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cache_ctrl #(.LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_tag(cpu_tag),
      .cpu_off(cpu_off), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .set_rd(set_rd), .set_we(set_we), .set_wp(set_wp), .set_wd(set_wd),
      .set_ctag(set_ctag), .set_ctag_w(set_ctag_w), .set_data_w(set_data_w),
      .set_hit(set_hit), .set_h_data(set_h_data), .set_r_dirty(set_r_dirty),
      .set_r_ctag(set_r_ctag), .set_r_data(set_r_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_tag(mem_tag), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0]       exp_q[$];
   logic [W_DATA-1:0] ref_mem [256];
   logic              model_init;

   function automatic logic [W_DATA-1:0] init_line(input int tag);
      logic [W_DATA-1:0] l;
      for (int w = 0; w < LW; w++) l[w*32 +: 32] = {8'hC0, tag[7:0], 8'h00, w[7:0]};
      if (tag == 'h12) l[95:64] = 32'hA5A5_A5A5;
      return l;
   endfunction

   // ---------------- set model: 4 ways, tree pseudo-LRU, invalid ways fill first
   logic              way_valid [4];
   logic              way_dirty [4];
   logic [W_CTAG-1:0] way_tag   [4];
   logic [W_DATA-1:0] way_data  [4];
   logic [2:0]        plru;
   int                hit_way, repl_way;

   always_comb begin
      hit_way = 0;
      set_hit = 1'b0;
      for (int i = 0; i < 4; i++)
         if (!set_hit && way_valid[i] && way_tag[i] == set_ctag) begin
            set_hit = 1'b1;
            hit_way = i;
         end
      repl_way = plru[0] ? (plru[2] ? 3 : 2) : (plru[1] ? 1 : 0);
      for (int i = 3; i >= 0; i--) if (!way_valid[i]) repl_way = i;
      set_h_data  = way_data[hit_way];
      set_r_dirty = way_valid[repl_way] && way_dirty[repl_way];
      set_r_ctag  = way_tag[repl_way];
      set_r_data  = way_data[repl_way];
   end

   always @(posedge clk) begin
      if (model_init) begin
         plru <= 3'b000;
         for (int i = 0; i < 4; i++) begin
            way_valid[i] <= 1'b0;
            way_dirty[i] <= 1'b0;
            way_tag[i]   <= '0;
            way_data[i]  <= '0;
         end
      end else begin
         if (set_rd && set_hit) begin
            if (hit_way < 2) begin
               plru[0] <= 1'b1;
               plru[1] <= (hit_way == 0);
            end else begin
               plru[0] <= 1'b0;
               plru[2] <= (hit_way == 2);
            end
         end
         if (set_we && set_wp) begin
            way_valid[repl_way] <= 1'b1;
            way_dirty[repl_way] <= 1'b0;
            way_tag[repl_way]   <= set_ctag_w;
            way_data[repl_way]  <= set_data_w;
         end else if (set_we) begin
            for (int i = 0; i < 4; i++)
               if (way_valid[i] && way_tag[i] == set_ctag_w) begin
                  way_data[i]  <= set_data_w;
                  way_dirty[i] <= 1'b1;
               end
         end
      end
   end

   // ---------------- memory model: ack after mem_lat wait cycles (0 = same cycle)
   int                mem_lat;
   int                mem_cnt;
   logic              stray_ack;
   logic [W_DATA-1:0] mem_store [256];

   always_comb begin
      mem_ack   = stray_ack || (mem_req && mem_cnt >= mem_lat);
      mem_rdata = mem_store[mem_tag];
   end

   always @(posedge clk) begin
      if (model_init) begin
         mem_cnt <= 0;
         for (int i = 0; i < 256; i++) mem_store[i] <= init_line(i);
      end else begin
         mem_cnt <= (!mem_req || mem_ack) ? 0 : mem_cnt + 1;
         if (mem_req && mem_ack && mem_we) mem_store[mem_tag] <= mem_wdata;
      end
   end

   // ---------------- passive monitor: running counters sampled mid-cycle
   int                obs_mem_cycles = 0, obs_wb_cycles = 0, obs_wb_unstable = 0, obs_fill = 0;
   logic [W_CTAG-1:0] obs_wb_tag, obs_refill_tag;
   logic [W_DATA-1:0] obs_wb_data, obs_fill_data;
   logic              obs_fill_wd;
   logic              prev_wb = 1'b0;

   always @(negedge clk) begin
      if (mem_req) obs_mem_cycles++;
      if (mem_req && mem_we) begin
         if (!prev_wb) begin
            obs_wb_tag  = mem_tag;
            obs_wb_data = mem_wdata;
         end else if (mem_tag !== obs_wb_tag || mem_wdata !== obs_wb_data) begin
            obs_wb_unstable++;
         end
         obs_wb_cycles++;
      end
      prev_wb = mem_req && mem_we;
      if (mem_req && !mem_we) obs_refill_tag = mem_tag;
      if (set_we && set_wp) begin
         obs_fill++;
         obs_fill_data = set_data_w;
         obs_fill_wd   = set_wd;
      end
   end

   // ---------------- one CPU access through the scoreboard
   logic              ack_we, ack_wp, ack_wd, ack_ready;
   logic [W_DATA-1:0] ack_data_w;

   task automatic do_access(input logic we, input logic [7:0] tag, input logic [1:0] off,
                            input logic [31:0] wd, output int lat);
      int          n;
      logic [31:0] exp;
      n = 0;
      while (cpu_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_tag   = tag;
      cpu_off   = off;
      cpu_wdata = wd;
      if (we) ref_mem[tag][{off, 5'b0} +: 32] = wd;
      exp_q.push_back(ref_mem[tag][{off, 5'b0} +: 32]);
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      lat     = 1;
      while (cpu_ack !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      ack_we     = set_we;
      ack_wp     = set_wp;
      ack_wd     = set_wd;
      ack_ready  = cpu_ready;
      ack_data_w = set_data_w;
      checks++;
      if (cpu_ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_timeout tag=%h got no cpu_ack within %0d cycles", tag, lat);
         exp_q.delete();
      end else begin
         exp = exp_q.pop_front();
         if (cpu_rdata !== exp) begin
            errors++;
            $display("FAIL rdata tag=%h off=%0d got %h exp %h", tag, off, cpu_rdata, exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      rst        = 1'b1;
      model_init = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_init = 1'b0;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cpu_ready); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", cpu_ack); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", cpu_rdata); end
      checks++;
      if ({set_rd, set_we, set_wp, set_wd} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_set_strobes got %b exp 0000", {set_rd, set_we, set_wp, set_wd});
      end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_cold_read();
      int lat, wb0, fill0;
      mem_lat = 2;
      wb0     = obs_wb_cycles;
      fill0   = obs_fill;
      do_access(1'b0, 8'h12, 2'd2, 32'h0, lat);
      checks++; if (lat != 5) begin errors++; $display("FAIL cold_latency got %0d exp 5", lat); end
      checks++; if (obs_wb_cycles != wb0) begin errors++; $display("FAIL cold_no_wb got %0d exp 0", obs_wb_cycles - wb0); end
      checks++; if (obs_refill_tag !== 8'h12) begin errors++; $display("FAIL cold_refill_tag got %h exp 12", obs_refill_tag); end
      checks++; if (obs_fill != fill0 + 1) begin errors++; $display("FAIL cold_fill_count got %0d exp 1", obs_fill - fill0); end
      checks++; if (obs_fill_data !== init_line('h12)) begin errors++; $display("FAIL cold_fill_data got %h exp %h", obs_fill_data, init_line('h12)); end
      checks++; if (obs_fill_wd !== 1'b0) begin errors++; $display("FAIL cold_fill_wd got %b exp 0", obs_fill_wd); end
   endtask

   task automatic test_read_hit();
      int lat, m0;
      m0 = obs_mem_cycles;
      do_access(1'b0, 8'h12, 2'd0, 32'h0, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL hit_latency got %0d exp 1", lat); end
      checks++; if (obs_mem_cycles != m0) begin errors++; $display("FAIL hit_mem_cycles got %0d exp 0", obs_mem_cycles - m0); end
      checks++; if (ack_ready !== 1'b0) begin errors++; $display("FAIL hit_ready_in_ack got %b exp 0", ack_ready); end
   endtask

   task automatic test_write_hit();
      int lat;
      do_access(1'b1, 8'h12, 2'd1, 32'hDEAD_BEEF, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL whit_latency got %0d exp 1", lat); end
      checks++;
      if ({ack_we, ack_wp, ack_wd} !== 3'b101) begin
         errors++;
         $display("FAIL whit_strobes we/wp/wd got %b exp 101", {ack_we, ack_wp, ack_wd});
      end
      checks++;
      if (ack_data_w !== ref_mem[8'h12]) begin
         errors++;
         $display("FAIL whit_data_w got %h exp %h", ack_data_w, ref_mem[8'h12]);
      end
   endtask

   task automatic test_fill_ways();
      int lat, wb0;
      mem_lat = 1;
      for (int i = 1; i <= 3; i++) begin
         wb0 = obs_wb_cycles;
         do_access(1'b1, 8'h20 + 8'(i), 2'(i), 32'h1111_0000 + i, lat);
         checks++; if (lat != 4) begin errors++; $display("FAIL fill_latency way%0d got %0d exp 4", i, lat); end
         checks++; if (obs_wb_cycles != wb0) begin errors++; $display("FAIL fill_no_wb way%0d got %0d exp 0", i, obs_wb_cycles - wb0); end
      end
   endtask

   task automatic test_dirty_evict();
      int lat, wb0, un0;
      mem_lat = 3;
      wb0     = obs_wb_cycles;
      un0     = obs_wb_unstable;
      do_access(1'b0, 8'h30, 2'd0, 32'h0, lat);
      checks++; if (obs_wb_cycles != wb0 + 4) begin errors++; $display("FAIL evict_wb_cycles got %0d exp 4", obs_wb_cycles - wb0); end
      checks++; if (obs_wb_unstable != un0) begin errors++; $display("FAIL evict_wb_stable got %0d changes exp 0", obs_wb_unstable - un0); end
      checks++; if (obs_wb_tag !== 8'h12) begin errors++; $display("FAIL evict_wb_tag got %h exp 12", obs_wb_tag); end
      checks++; if (obs_wb_data !== ref_mem[8'h12]) begin errors++; $display("FAIL evict_wb_data got %h exp %h", obs_wb_data, ref_mem[8'h12]); end
      checks++; if (lat != 10) begin errors++; $display("FAIL evict_latency got %0d exp 10", lat); end
   endtask

   task automatic test_zero_wait();
      int lat, wb0;
      mem_lat = 0;
      wb0     = obs_wb_cycles;
      do_access(1'b0, 8'h31, 2'd3, 32'h0, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL zw_latency got %0d exp 4", lat); end
      checks++; if (obs_wb_cycles != wb0 + 1) begin errors++; $display("FAIL zw_wb_cycles got %0d exp 1", obs_wb_cycles - wb0); end
      checks++; if (obs_wb_tag !== 8'h22) begin errors++; $display("FAIL zw_wb_tag got %h exp 22", obs_wb_tag); end
   endtask

   task automatic test_reset_refill();
      int n, fill0;
      mem_lat = 20;
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_we  = 1'b0;
      cpu_tag = 8'h40;
      cpu_off = 2'd0;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      n = 0;
      while (!(mem_req === 1'b1 && mem_we === 1'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n >= 100) begin errors++; $display("FAIL rr_reach_refill got %0d cycles exp <100", n); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rr_mem_req got %b exp 0", mem_req); end
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rr_ready got %b exp 1", cpu_ready); end
      rst       = 1'b0;
      fill0     = obs_fill;
      @(negedge clk);
      stray_ack = 1'b1;
      #1;
      checks++; if (set_we !== 1'b0) begin errors++; $display("FAIL rr_stray_set_we got %b exp 0", set_we); end
      @(negedge clk);
      stray_ack = 1'b0;
      @(negedge clk);
      checks++; if (obs_fill != fill0) begin errors++; $display("FAIL rr_stray_fill got %0d exp 0", obs_fill - fill0); end
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rr_stray_ready got %b exp 1", cpu_ready); end
   endtask

   task automatic test_back_to_back();
      int lat;
      mem_lat = 1;
      do_access(1'b0, 8'h12, 2'd1, 32'h0, lat);
      do_access(1'b0, 8'h12, 2'd2, 32'h0, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL b2b_hit_latency got %0d exp 1", lat); end
      do_access(1'b0, 8'h22, 2'd2, 32'h0, lat);
      do_access(1'b1, 8'h21, 2'd0, 32'h0BAD_CAFE, lat);
      do_access(1'b0, 8'h21, 2'd0, 32'h0, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_tag    = '0;
      cpu_off    = '0;
      cpu_wdata  = '0;
      stray_ack  = 1'b0;
      mem_lat    = 1;
      model_init = 1'b1;
      rst        = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_line(i);

      test_reset();
      test_cold_read();
      test_read_hit();
      test_write_hit();
      test_fill_ways();
      test_dirty_evict();
      test_zero_wait();
      test_reset_refill();
      test_back_to_back();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for one 4-way cache set with pseudo-LRU replacement. It accepts single-word CPU read/write requests, performs the tag lookup, and serves hits directly. On a miss it writes back a dirty victim line, refills the line from memory, and replays the access. It sits between the CPU-side memory port and the set's control pins (`rd`, `we`, `wp`, `wd`, `ctag`, `ctag_w`, `data_w`) on one side, and a line-granular memory port on the other.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per line; must equal `W_DATA`/32. Offset width is `$clog2(LINE_WORDS)`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_req` in 1: access request.
- `cpu_ready` out 1: high only in IDLE; a request is accepted on a cycle with `cpu_req & cpu_ready`.
- `cpu_we` in 1: 1 = write.
- `cpu_tag` in `W_CTAG`: line tag.
- `cpu_off` in `$clog2(LINE_WORDS)`: word offset within the line.
- `cpu_wdata` in 32: write word.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: valid while `cpu_ack` is high. For reads it is the addressed word; for writes it is the newly written word.
- `set_rd`, `set_we`, `set_wp`, `set_wd` out 1 each: set controls.
- `set_ctag` out `W_CTAG`: lookup tag.
- `set_ctag_w` out `W_CTAG`: write tag.
- `set_data_w` out `W_DATA`: write line.
- `set_hit` in 1, `set_h_data` in `W_DATA`: hit indication and hit-line data.
- `set_r_dirty` in 1, `set_r_ctag` in `W_CTAG`, `set_r_data` in `W_DATA`: replacement-line status, tag and data.
- `mem_req` out 1, `mem_we` out 1: memory request and direction.
- `mem_tag` out `W_CTAG`, `mem_wdata` out `W_DATA`: memory address tag and write line.
- `mem_ack` in 1, `mem_rdata` in `W_DATA`: one-cycle acknowledge; read data is valid in the ack cycle.

## Operation
- Acceptance registers `cpu_we`, `cpu_tag`, `cpu_off` and `cpu_wdata` into a request latch; all later states use the latched values.
- IDLE: `cpu_ready`=1. On acceptance go to LOOKUP.
- LOOKUP: `set_ctag` = latched tag.
  - Hit: `set_rd`=1 (updates LRU) and `cpu_ack`=1. For a read, `cpu_rdata` = word `off` of `set_h_data`. For a write, also assert `set_we`=1, `set_wp`=0, `set_wd`=1, with `set_data_w` = `set_h_data` with word `off` replaced by `cpu_wdata`, and `set_ctag_w` = latched tag. Go to IDLE.
  - Miss: `set_rd`=0. If `set_r_dirty`, go to WB; otherwise go to REFILL.
- WB: `mem_req`=1, `mem_we`=1, `mem_tag`=`set_r_ctag`, `mem_wdata`=`set_r_data`, all held stable until `mem_ack`. The replacement outputs remain stable because LRU changes only on `rd & hit`. On `mem_ack` go to REFILL.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_tag` = latched tag. In the `mem_ack` cycle assert `set_we`=1, `set_wp`=1, `set_wd`=0, `set_ctag_w` = latched tag, `set_data_w` = `mem_rdata`, then go to LOOKUP. The replay then hits, updates LRU, and for writes merges the word and sets the dirty bit.
- Outside the cases above, every set control and memory control output is 0. `mem_tag` and `mem_wdata` are don't-care when `mem_req`=0.
- Reset: state returns to IDLE. Outputs: `cpu_ready`=1, `cpu_ack`=0, `cpu_rdata`=0, all `set_*` strobes 0, `mem_req`=0, request latch cleared.
- Reset during WB or REFILL abandons the memory transaction. The memory side must tolerate `mem_req` dropping without an ack.
- A `mem_ack` arriving while `mem_req`=0 is ignored.

## Timing
- Read or write hit: accepted at edge t, `cpu_ack` at t+1 (one cycle after acceptance).
- Clean miss: LOOKUP at t+1, REFILL from t+2; with `mem_ack` at t+2+k, `cpu_ack` at t+3+k.
- Dirty miss: adds the WB handshake (≥1 cycle) before REFILL.
- `cpu_ready` is 0 from LOOKUP until the cycle after `cpu_ack`. There are no back-to-back acceptances; peak throughput is one access per 2 cycles.
- `mem_ack` in the same cycle `mem_req` first rises is legal (zero wait states).
- Combinational paths: set outputs → `cpu_ack`/`cpu_rdata`/`set_we` within LOOKUP, and `mem_ack` → `set_we` within REFILL.

## Structure
- Shared package `includes`: `W_CTAG`, `W_DATA`, `LINE_WORDS`, and the `cache_ctrl_state_t` enum {IDLE, LOOKUP, WB, REFILL}.
- One sub-module, `line_merge`: combinational; replaces word `off` of a line with a 32-bit word. Used for write hits.
- The FSM and request latch live in `cache_ctrl`.

## Test plan
- Cold read, tag 0x12, off 2 → no WB. REFILL `mem_tag`=0x12; memory returns a line with word2=0xA5A5A5A5 → fill with `set_wp`=1, replay hit, `cpu_rdata`=0xA5A5A5A5.
- Read hit to an already-filled line → `cpu_ack` exactly 1 cycle after acceptance, zero `mem_req` cycles.
- Write hit, word 0xDEADBEEF, off 1 → `set_we`=1, `set_wp`=0, `set_wd`=1, `set_data_w` word1=0xDEADBEEF with other words unchanged, `cpu_ack` at t+1.
- Fill all 4 ways with dirty lines, then miss on a fifth tag → WB emits `set_r_ctag`/`set_r_data` of the LRU way with `mem_we`=1, held across 3 wait cycles; then REFILL.
- Zero-wait memory (ack same cycle as req) on a dirty miss → `cpu_ack` at t+4.
- `rst` asserted mid-REFILL → next cycle `mem_req`=0 and `cpu_ready`=1; a later stray `mem_ack` causes no set write.
